// File: rtl/multicycle_control_if.sv
// Control-unit bundle: instruction fields and flags in, datapath enables/selects,
// status and debug out. The control unit sits on the slave side.
interface multicycle_control_if #(
    parameter int CNTW = 32
);
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic            zero;
    logic            iord;
    logic            memwrite;
    logic            irwrite;
    logic            regdst;
    logic            memtoreg;
    logic            regwrite;
    logic            alusrca;
    logic [1:0]      alusrcb;
    logic [1:0]      pcsrc;
    logic            pcen;
    logic [2:0]      alucontrol;
    logic            illegal;
    logic            illegal_seen;
    logic [CNTW-1:0] retired;
    logic [3:0]      state;

    modport slave (
        input  opcode, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pcen, alucontrol, illegal, illegal_seen,
               retired, state
    );

    modport master (
        output opcode, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pcen, alucontrol, illegal, illegal_seen,
               retired, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: Moore decode of every datapath control from the
// current state, plus illegal-instruction flags and a retired-instruction counter.
module multicycle_control #(
    parameter bit ENABLE_IMM  = 1'b1,
    parameter bit ENABLE_JUMP = 1'b1,
    parameter int CNTW        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11,
        S_RESET   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t          state_q, state_d;
    logic            illegal_seen_q, illegal_seen_d;
    logic [CNTW-1:0] retired_q, retired_d;

    logic       iord_s, memwrite_s, irwrite_s, regdst_s, memtoreg_s;
    logic       regwrite_s, alusrca_s, pcwrite_s, branch_s, illegal_s;
    logic [1:0] alusrcb_s, pcsrc_s;
    logic [2:0] alucontrol_s;
    logic       terminal_s;

    function automatic logic opcode_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ: ok = 1'b1;
            OP_ADDI, OP_SLTI:               ok = ENABLE_IMM;
            OP_J:                           ok = ENABLE_JUMP;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic funct_known(input logic [5:0] fn);
        logic ok;
        case (fn)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: ok = 1'b1;
            default:                                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Unknown funct codes fall back to add so the write-back still has a defined value.
    function automatic logic [2:0] alu_from_funct(input logic [5:0] fn);
        logic [2:0] alu;
        case (fn)
            6'b100000: alu = ALU_ADD;
            6'b100010: alu = ALU_SUB;
            6'b100100: alu = ALU_AND;
            6'b100101: alu = ALU_OR;
            6'b101010: alu = ALU_SLT;
            default:   alu = ALU_ADD;
        endcase
        return alu;
    endfunction

    // State, sticky illegal flag and retirement counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_RESET;
            illegal_seen_q <= 1'b0;
            retired_q      <= '0;
        end else begin
            state_q        <= state_d;
            illegal_seen_q <= illegal_seen_d;
            retired_q      <= retired_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI, OP_SLTI: begin
                        if (ENABLE_IMM) begin
                            state_d = S_IMMEX;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                    OP_J: begin
                        if (ENABLE_JUMP) begin
                            state_d = S_JEX;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_IMMEX:   state_d = S_IMMWB;
            S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_IMMWB, S_JEX: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore control decode; only alucontrol/illegal look at the sampled IR fields.
    always_comb begin
        iord_s       = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        regdst_s     = 1'b0;
        memtoreg_s   = 1'b0;
        regwrite_s   = 1'b0;
        alusrca_s    = 1'b0;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        illegal_s    = 1'b0;
        alusrcb_s    = 2'b00;
        pcsrc_s      = 2'b00;
        alucontrol_s = 3'b000;
        terminal_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite_s    = 1'b1;
                pcwrite_s    = 1'b1;
                alusrcb_s    = 2'b01;
                alucontrol_s = ALU_ADD;
            end
            S_DECODE: begin
                alusrcb_s    = 2'b11;
                alucontrol_s = ALU_ADD;
                illegal_s    = ~opcode_legal(bus.opcode);
            end
            S_MEMADR: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = 2'b10;
                alucontrol_s = ALU_ADD;
            end
            S_MEMRD: iord_s = 1'b1;
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
                terminal_s = 1'b1;
            end
            S_MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                terminal_s = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca_s    = 1'b1;
                alucontrol_s = alu_from_funct(bus.funct);
                illegal_s    = ~funct_known(bus.funct);
            end
            S_RTYPEWB: begin
                regwrite_s = 1'b1;
                regdst_s   = 1'b1;
                terminal_s = 1'b1;
            end
            S_BEQEX: begin
                alusrca_s    = 1'b1;
                alucontrol_s = ALU_SUB;
                branch_s     = 1'b1;
                pcsrc_s      = 2'b01;
                terminal_s   = 1'b1;
            end
            S_IMMEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (bus.opcode == OP_SLTI) begin
                    alucontrol_s = ALU_SLT;
                end else begin
                    alucontrol_s = ALU_ADD;
                end
            end
            S_IMMWB: begin
                regwrite_s = 1'b1;
                terminal_s = 1'b1;
            end
            S_JEX: begin
                pcwrite_s  = 1'b1;
                pcsrc_s    = 2'b10;
                terminal_s = 1'b1;
            end
            default: begin
                iord_s = 1'b0;
            end
        endcase
    end

    // Sticky illegal flag and retirement count on leaving a terminal state.
    always_comb begin
        illegal_seen_d = illegal_seen_q | illegal_s;
        if (terminal_s) begin
            retired_d = retired_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
    end

    assign bus.iord         = iord_s;
    assign bus.memwrite     = memwrite_s;
    assign bus.irwrite      = irwrite_s;
    assign bus.regdst       = regdst_s;
    assign bus.memtoreg     = memtoreg_s;
    assign bus.regwrite     = regwrite_s;
    assign bus.alusrca      = alusrca_s;
    assign bus.alusrcb      = alusrcb_s;
    assign bus.pcsrc        = pcsrc_s;
    assign bus.pcen         = pcwrite_s | (branch_s & bus.zero);
    assign bus.alucontrol   = alucontrol_s;
    assign bus.illegal      = illegal_s;
    assign bus.illegal_seen = illegal_seen_q;
    assign bus.retired      = retired_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: default, feature-disabled and 3-bit-counter
// instances share one clock, reset and instruction stream.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode_s = 6'd0;
    logic [5:0] funct_s = 6'd0;
    logic       zero_s = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctl;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    multicycle_control_if #(.CNTW(32)) if_d ();
    multicycle_control_if #(.CNTW(32)) if_n ();
    multicycle_control_if #(.CNTW(3))  if_w ();

    assign if_d.opcode = opcode_s;
    assign if_d.funct  = funct_s;
    assign if_d.zero   = zero_s;
    assign if_n.opcode = opcode_s;
    assign if_n.funct  = funct_s;
    assign if_n.zero   = zero_s;
    assign if_w.opcode = opcode_s;
    assign if_w.funct  = funct_s;
    assign if_w.zero   = zero_s;

    multicycle_control #(.ENABLE_IMM(1'b1), .ENABLE_JUMP(1'b1), .CNTW(32)) dut_d (
        .clk(clk), .rst_n(rst_n), .bus(if_d));
    multicycle_control #(.ENABLE_IMM(1'b0), .ENABLE_JUMP(1'b0), .CNTW(32)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(if_n));
    multicycle_control #(.ENABLE_IMM(1'b1), .ENABLE_JUMP(1'b1), .CNTW(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(if_w));

    wire [15:0] obs_ctl = {if_d.iord, if_d.memwrite, if_d.irwrite, if_d.regdst,
                           if_d.memtoreg, if_d.regwrite, if_d.alusrca, if_d.alusrcb,
                           if_d.pcsrc, if_d.pcen, if_d.alucontrol, if_d.illegal};

    // Expected controls for a state, written straight from the control table.
    function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z);
        logic       iord, mw, irw, rd, m2r, rw, sa, pcen, ill;
        logic [1:0] sb, ps;
        logic [2:0] alu;
        {iord, mw, irw, rd, m2r, rw, sa, pcen, ill} = 9'd0;
        sb = 2'b00; ps = 2'b00; alu = 3'b000;
        case (st)
            4'd0:  begin irw = 1'b1; pcen = 1'b1; sb = 2'b01; alu = 3'b010; end
            4'd1:  begin
                sb = 2'b11; alu = 3'b010;
                ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                   6'b001000, 6'b001010, 6'b000010});
            end
            4'd2:  begin sa = 1'b1; sb = 2'b10; alu = 3'b010; end
            4'd3:  iord = 1'b1;
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin iord = 1'b1; mw = 1'b1; end
            4'd6:  begin
                sa = 1'b1;
                case (fn)
                    6'b100000: alu = 3'b010;
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    default:   begin alu = 3'b010; ill = 1'b1; end
                endcase
            end
            4'd7:  begin rw = 1'b1; rd = 1'b1; end
            4'd8:  begin sa = 1'b1; alu = 3'b110; ps = 2'b01; pcen = z; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; alu = (op == 6'b001010) ? 3'b111 : 3'b010; end
            4'd10: rw = 1'b1;
            4'd11: begin pcen = 1'b1; ps = 2'b10; end
            default: ;
        endcase
        return {iord, mw, irw, rd, m2r, rw, sa, sb, ps, pcen, alu, ill};
    endfunction

    function automatic exp_t mk(input logic [3:0] st, input logic [5:0] op,
                                input logic [5:0] fn, input logic z);
        exp_t e;
        e.st  = st;
        e.ctl = exp_ctl(st, op, fn, z);
        return e;
    endfunction

    // Drives one instruction from FETCH, queueing its expected state trace, then checks it per cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        exp_t e;
        opcode_s = op; funct_s = fn; zero_s = z;
        sb_q.push_back(mk(4'd0, op, fn, z));
        sb_q.push_back(mk(4'd1, op, fn, z));
        case (op)
            6'b100011: begin
                sb_q.push_back(mk(4'd2, op, fn, z));
                sb_q.push_back(mk(4'd3, op, fn, z));
                sb_q.push_back(mk(4'd4, op, fn, z));
            end
            6'b101011: begin
                sb_q.push_back(mk(4'd2, op, fn, z));
                sb_q.push_back(mk(4'd5, op, fn, z));
            end
            6'b000000: begin
                sb_q.push_back(mk(4'd6, op, fn, z));
                sb_q.push_back(mk(4'd7, op, fn, z));
            end
            6'b000100: sb_q.push_back(mk(4'd8, op, fn, z));
            6'b001000, 6'b001010: begin
                sb_q.push_back(mk(4'd9, op, fn, z));
                sb_q.push_back(mk(4'd10, op, fn, z));
            end
            6'b000010: sb_q.push_back(mk(4'd11, op, fn, z));
            default: ;
        endcase
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_tests++;
            if (if_d.state !== e.st) begin
                n_fail++;
                $display("FAIL seq_state op=%b fn=%b: got %0d expected %0d", op, fn, if_d.state, e.st);
            end
            n_tests++;
            if (obs_ctl !== e.ctl) begin
                n_fail++;
                $display("FAIL seq_ctl op=%b state=%0d: got %b expected %b", op, e.st, obs_ctl, e.ctl);
            end
            @(posedge clk);
            @(negedge clk);
        end
        // back in FETCH for the next instruction
        n_tests++;
        if (if_d.state !== 4'd0) begin
            n_fail++;
            $display("FAIL return_fetch op=%b: got %0d expected 0", op, if_d.state);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        opcode_s = 6'd0; funct_s = 6'd0; zero_s = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_tests++;
        if (if_d.state !== 4'd15 || obs_ctl !== 16'd0 || if_d.retired !== 32'd0 || if_d.illegal_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: state=%0d ctl=%b retired=%0d seen=%b expected 15/0/0/0",
                     if_d.state, obs_ctl, if_d.retired, if_d.illegal_seen);
        end
        rst_n = 1'b1;
        opcode_s = 6'b100011;
        @(negedge clk);
        n_tests++;
        if (if_d.state !== 4'd0) begin
            n_fail++; $display("FAIL reset_release: state got %0d expected 0", if_d.state);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (if_d.state !== 4'd3 || if_d.iord !== 1'b1) begin
            n_fail++; $display("FAIL reach_memrd: state=%0d iord=%b expected 3/1", if_d.state, if_d.iord);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (if_d.state !== 4'd15 || obs_ctl !== 16'd0) begin
            n_fail++; $display("FAIL async_reset: state=%0d ctl=%b expected 15/0", if_d.state, obs_ctl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (if_d.state !== 4'd0) begin
            n_fail++; $display("FAIL rerelease_fetch: state got %0d expected 0", if_d.state);
        end
        @(negedge clk);
        n_tests++;
        if (if_d.state !== 4'd1 || if_d.retired !== 32'd0) begin
            n_fail++; $display("FAIL rerelease_decode: state=%0d retired=%0d expected 1/0", if_d.state, if_d.retired);
        end
    endtask

    task automatic test_load_store();
        apply_reset();
        run_instr(6'b100011, 6'd0, 1'b0);
        run_instr(6'b101011, 6'd0, 1'b0);
        n_tests++;
        if (if_d.retired !== 32'd2) begin
            n_fail++; $display("FAIL ls_retired: got %0d expected 2", if_d.retired);
        end
    endtask

    task automatic test_rtype();
        apply_reset();
        run_instr(6'b000000, 6'b100010, 1'b0);
        run_instr(6'b000000, 6'b101010, 1'b0);
        n_tests++;
        if (if_d.illegal_seen !== 1'b0) begin
            n_fail++; $display("FAIL seen_before: got %b expected 0", if_d.illegal_seen);
        end
        run_instr(6'b000000, 6'b111111, 1'b0);
        n_tests++;
        if (if_d.illegal_seen !== 1'b1 || if_d.retired !== 32'd3) begin
            n_fail++; $display("FAIL rtype_after_bad: seen=%b retired=%0d expected 1/3", if_d.illegal_seen, if_d.retired);
        end
        run_instr(6'b000000, 6'b100101, 1'b0);
        n_tests++;
        if (if_d.illegal_seen !== 1'b1) begin
            n_fail++; $display("FAIL seen_sticky: got %b expected 1", if_d.illegal_seen);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        run_instr(6'b000100, 6'd0, 1'b1);
        run_instr(6'b000100, 6'd0, 1'b0);
        n_tests++;
        if (if_d.retired !== 32'd2) begin
            n_fail++; $display("FAIL beq_retired: got %0d expected 2", if_d.retired);
        end
    endtask

    task automatic test_params();
        logic [5:0] ops [2];
        ops[0] = 6'b001000;
        ops[1] = 6'b000010;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            opcode_s = ops[i];
            #1;
            n_tests++;
            if (if_n.state !== 4'd0) begin
                n_fail++; $display("FAIL noext_fetch op=%b: got %0d expected 0", ops[i], if_n.state);
            end
            @(negedge clk);
            n_tests++;
            if (if_n.state !== 4'd1 || if_n.illegal !== 1'b1) begin
                n_fail++; $display("FAIL noext_decode op=%b: state=%0d illegal=%b expected 1/1", ops[i], if_n.state, if_n.illegal);
            end
            @(negedge clk);
            n_tests++;
            if (if_n.state !== 4'd0 || if_n.retired !== 32'd0 || if_n.illegal_seen !== 1'b1) begin
                n_fail++; $display("FAIL noext_back op=%b: state=%0d retired=%0d seen=%b expected 0/0/1",
                                   ops[i], if_n.state, if_n.retired, if_n.illegal_seen);
            end
        end
        apply_reset();
        run_instr(6'b001000, 6'd0, 1'b0);
        run_instr(6'b001010, 6'd0, 1'b0);
        run_instr(6'b000010, 6'd0, 1'b0);
        run_instr(6'b111111, 6'd0, 1'b0);
        n_tests++;
        if (if_d.retired !== 32'd3 || if_d.illegal_seen !== 1'b1) begin
            n_fail++; $display("FAIL imm_j_retired: retired=%0d seen=%b expected 3/1", if_d.retired, if_d.illegal_seen);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        repeat (8) run_instr(6'b000000, 6'b100000, 1'b0);
        n_tests++;
        if (if_w.retired !== 3'd0) begin
            n_fail++; $display("FAIL wrap_zero: got %0d expected 0", if_w.retired);
        end
        run_instr(6'b000000, 6'b100100, 1'b0);
        n_tests++;
        if (if_w.retired !== 3'd1 || if_d.retired !== 32'd9) begin
            n_fail++; $display("FAIL wrap_one: narrow=%0d wide=%0d expected 1/9", if_w.retired, if_d.retired);
        end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_rtype();
        test_branch();
        test_params();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
